sva_thread_sched: RTL and testbench

SVA_THREAD_SCHED -- requirements
Module: sva_thread_sched

---
 rtl/sva_sched_pkg.sv | 11 +
 rtl/sva_prio_enc.sv | 15 +
 rtl/sva_thread_sched.sv | 123 ++++++++++++
 tb/tb_sva_thread_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sva_sched_pkg.sv
// sva_sched_pkg: shared slot record, scheduler FSM encoding and counter width
package sva_sched_pkg;
    localparam int CNT_W = 16;
    localparam int SLOT_FIELD_W = 32;
    typedef enum logic [2:0] {IDLE, SCAN, REQ, SPAWN_REQ, DONE} fsm_e;
    typedef struct packed {
        logic                    active;
        logic [SLOT_FIELD_W-1:0] start;
        logic [SLOT_FIELD_W-1:0] state;
    } slot_t;
endpackage

// File: rtl/sva_prio_enc.sv
// sva_prio_enc: index of the lowest set bit of a request vector
module sva_prio_enc #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) idx_o = req_i[i] ? IW'(i) : idx_o;
    end
    assign found_o = |req_i;
endmodule

// File: rtl/sva_thread_sched.sv
// sva_thread_sched: per-tick round-robin of SVA thread slots through a shared evaluator
module sva_thread_sched
    import sva_sched_pkg::*;
#(
    parameter int SLOT_NUM    = 8,
    parameter int STATE_WIDTH = 8,
    parameter int TIMER_WIDTH = 8,
    parameter int INIT_STATE  = 0,
    localparam int IW = $clog2(SLOT_NUM)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   tick,
    output logic                   eval_req,
    output logic [IW-1:0]          eval_slot,
    output logic [STATE_WIDTH-1:0] eval_state,
    output logic [TIMER_WIDTH-1:0] eval_start,
    input  logic                   eval_ack,
    input  logic [STATE_WIDTH-1:0] eval_next_state,
    input  logic                   eval_keep,
    input  logic                   eval_succ,
    input  logic                   eval_fail,
    output logic                   busy,
    output logic [IW:0]            active_cnt,
    output logic [TIMER_WIDTH-1:0] period,
    output logic [CNT_W-1:0]       succ_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic                   missed_tick,
    output logic                   overflow
);
    fsm_e                   state_q, state_d;
    slot_t                  slot_q [SLOT_NUM];
    logic [SLOT_NUM-1:0]    act, act_d, pend_q;
    logic [IW-1:0]          pend_idx, free_idx, cur_q;
    logic                   pend_any, free_any, ack;
    logic [STATE_WIDTH-1:0] cur_state_q;
    logic [TIMER_WIDTH-1:0] cur_start_q, period_q, round_period_q;
    logic [CNT_W-1:0]       succ_q, fail_q;
    logic [IW:0]            pop, active_cnt_q;
    logic                   missed_q, overflow_q;

    sva_prio_enc #(.N(SLOT_NUM)) u_next (.req_i(pend_q), .idx_o(pend_idx), .found_o(pend_any));
    sva_prio_enc #(.N(SLOT_NUM)) u_free (.req_i(~act), .idx_o(free_idx), .found_o(free_any));

    assign eval_req    = state_q == REQ || state_q == SPAWN_REQ;
    assign ack         = eval_req && eval_ack;
    assign busy        = state_q != IDLE;
    assign eval_slot   = cur_q;
    assign eval_state  = cur_state_q;
    assign eval_start  = cur_start_q;
    assign period      = period_q;
    assign succ_cnt    = succ_q;
    assign fail_cnt    = fail_q;
    assign active_cnt  = active_cnt_q;
    assign missed_tick = missed_q;
    assign overflow    = overflow_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = tick ? SCAN : IDLE;
            SCAN:      state_d = pend_any ? REQ : free_any ? SPAWN_REQ : DONE;
            REQ:       state_d = eval_ack ? SCAN : REQ;
            SPAWN_REQ: state_d = eval_ack ? DONE : SPAWN_REQ;
            default:   state_d = IDLE;
        endcase
    end

    // An ack leaves the addressed slot active exactly when the evaluator asks to keep it,
    // which covers both retiring an existing thread and committing a spawn.
    always_comb begin
        act_d = act;
        pop   = '0;
        for (int i = 0; i < SLOT_NUM; i++) act[i] = slot_q[i].active;
        act_d = act;
        if (ack) act_d[cur_q] = eval_keep;
        for (int i = 0; i < SLOT_NUM; i++) pop = pop + (IW + 1)'(act_d[i]);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            for (int i = 0; i < SLOT_NUM; i++) slot_q[i] <= '0;
            pend_q         <= '0;
            cur_q          <= '0;
            cur_state_q    <= '0;
            cur_start_q    <= '0;
            period_q       <= '0;
            round_period_q <= '0;
            succ_q         <= '0;
            fail_q         <= '0;
            active_cnt_q   <= '0;
            missed_q       <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_q + TIMER_WIDTH'(tick);
            missed_q     <= tick && busy;
            overflow_q   <= state_q == SCAN && !pend_any && !free_any;
            active_cnt_q <= pop;
            // Spawned threads start at the period of the tick that opened the round.
            if (state_q == IDLE && tick) begin
                pend_q         <= act;
                round_period_q <= period_q;
            end
            if (state_q == SCAN) begin
                cur_q       <= pend_any ? pend_idx : free_idx;
                cur_state_q <= pend_any ? STATE_WIDTH'(slot_q[pend_idx].state) : STATE_WIDTH'(INIT_STATE);
                cur_start_q <= pend_any ? TIMER_WIDTH'(slot_q[pend_idx].start) : round_period_q;
                if (pend_any) pend_q[pend_idx] <= 1'b0;
            end
            if (ack) begin
                slot_q[cur_q].active <= eval_keep;
                if (eval_keep) begin
                    slot_q[cur_q].state <= SLOT_FIELD_W'(eval_next_state);
                    slot_q[cur_q].start <= SLOT_FIELD_W'(cur_start_q);
                end
            end
            if (ack && eval_succ && succ_q != '1) succ_q <= succ_q + CNT_W'(1);
            if (ack && eval_fail && fail_q != '1) fail_q <= fail_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sva_thread_sched.sv
// tb_sva_thread_sched: directed and randomized rounds against a slot-pool reference model
module tb_sva_thread_sched;
    logic        clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic        eval_ack = 1'b0, eval_keep = 1'b0, eval_succ = 1'b0, eval_fail = 1'b0;
    logic [7:0]  eval_next_state = '0;
    logic        eval_req, busy, missed_tick, overflow;
    logic [2:0]  eval_slot;
    logic [7:0]  eval_state, eval_start, period;
    logic [3:0]  active_cnt;
    logic [15:0] succ_cnt, fail_cnt;

    int checks = 0, failures = 0;
    int ov_cnt = 0, mt_cnt = 0, exp_ov = 0, exp_mt = 0;
    bit          m_act [8];
    logic [7:0]  m_state [8], m_start [8], m_period = '0;
    logic [15:0] m_succ = '0, m_fail = '0;

    sva_thread_sched dut (
        .sys_clk(clk), .sys_rst(rst), .tick(tick),
        .eval_req(eval_req), .eval_slot(eval_slot), .eval_state(eval_state), .eval_start(eval_start),
        .eval_ack(eval_ack), .eval_next_state(eval_next_state), .eval_keep(eval_keep),
        .eval_succ(eval_succ), .eval_fail(eval_fail), .busy(busy), .active_cnt(active_cnt),
        .period(period), .succ_cnt(succ_cnt), .fail_cnt(fail_cnt),
        .missed_tick(missed_tick), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow) ov_cnt++;
        if (missed_tick) mt_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pre);
        chk({pre, "_eval_req"}, eval_req, 0);
        chk({pre, "_eval_slot"}, eval_slot, 0);
        chk({pre, "_eval_state"}, eval_state, 0);
        chk({pre, "_eval_start"}, eval_start, 0);
        chk({pre, "_busy"}, busy, 0);
        chk({pre, "_active_cnt"}, active_cnt, 0);
        chk({pre, "_period"}, period, 0);
        chk({pre, "_succ_cnt"}, succ_cnt, 0);
        chk({pre, "_fail_cnt"}, fail_cnt, 0);
        chk({pre, "_missed_tick"}, missed_tick, 0);
        chk({pre, "_overflow"}, overflow, 0);
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input bit en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    function automatic int model_pop();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_act[i]);
        return n;
    endfunction

    // Waits for a request, checks what is offered, holds it for dly cycles, then acks.
    task automatic serve(input string what, input int slot, input logic [7:0] st, input logic [7:0] ss,
                         input int dly, input bit k, input logic [7:0] nxt, input bit s, input bit f, input bit tm);
        int n = 0;
        while (!eval_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({what, "_req_seen"}, eval_req, 1);
        if (!eval_req) return;
        chk({what, "_slot"}, eval_slot, slot);
        chk({what, "_state"}, eval_state, st);
        chk({what, "_start"}, eval_start, ss);
        for (int d = 0; d < dly; d++) begin
            tick = tm && d == 1;
            @(negedge clk);
            chk({what, "_req_hold"}, eval_req, 1);
        end
        tick = 1'b0;
        chk({what, "_slot_stable"}, eval_slot, slot);
        eval_ack = 1'b1; eval_keep = k; eval_next_state = nxt; eval_succ = s; eval_fail = f;
        @(negedge clk);
        eval_ack = 1'b0; eval_keep = 1'b0; eval_succ = 1'b0; eval_fail = 1'b0;
        chk({what, "_req_drop"}, eval_req, 0);
    endtask

    task automatic run_round(input bit rnd, input int dly_max, input logic [7:0] keep_mask,
                             input bit spawn_keep, input bit tm);
        int snap[$];
        int free_slot, slot, dly;
        logic [7:0] rp, nxt;
        bit k, s, f, first;
        first = 1'b1;
        for (int i = 0; i < 8; i++) if (m_act[i]) snap.push_back(i);
        @(negedge clk);
        tick = 1'b1;
        rp = m_period;
        m_period++;
        @(negedge clk);
        tick = 1'b0;
        foreach (snap[j]) begin
            slot = snap[j];
            k    = rnd ? 1'($urandom) : keep_mask[slot];
            s    = rnd ? 1'($urandom) : !k;
            f    = rnd ? 1'($urandom) : 1'b0;
            nxt  = 8'($urandom);
            dly  = rnd ? int'($urandom_range(0, dly_max)) : dly_max;
            serve("eval", slot, m_state[slot], m_start[slot], dly, k, nxt, s, f, tm && first);
            if (tm && first) begin
                m_period++;
                exp_mt++;
            end
            first = 1'b0;
            if (k) m_state[slot] = nxt;
            else m_act[slot] = 1'b0;
            m_succ = sat_inc(m_succ, s);
            m_fail = sat_inc(m_fail, f);
        end
        free_slot = -1;
        for (int i = 7; i >= 0; i--) if (!m_act[i]) free_slot = i;
        if (free_slot < 0) begin
            exp_ov++;
            repeat (3) begin
                @(negedge clk);
                chk("no_spawn", eval_req, 0);
            end
        end else begin
            k   = rnd ? 1'($urandom) : spawn_keep;
            s   = rnd ? 1'($urandom) : 1'b0;
            f   = rnd ? 1'($urandom) : 1'b0;
            nxt = 8'($urandom);
            dly = rnd ? int'($urandom_range(0, dly_max)) : dly_max;
            serve("spawn", free_slot, 8'h00, rp, dly, k, nxt, s, f, tm && first);
            if (tm && first) begin
                m_period++;
                exp_mt++;
            end
            if (k) begin
                m_act[free_slot]   = 1'b1;
                m_state[free_slot] = nxt;
                m_start[free_slot] = rp;
            end
            m_succ = sat_inc(m_succ, s);
            m_fail = sat_inc(m_fail, f);
            repeat (2) @(negedge clk);
        end
        chk("end_busy", busy, 0);
        chk("end_active_cnt", active_cnt, model_pop());
        chk("end_period", period, m_period);
        chk("end_succ_cnt", succ_cnt, m_succ);
        chk("end_fail_cnt", fail_cnt, m_fail);
        chk("overflow_pulses", ov_cnt, exp_ov);
        chk("missed_pulses", mt_cnt, exp_mt);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            m_act[i] = 1'b0; m_state[i] = '0; m_start[i] = '0;
        end
        tick = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        tick = 1'b0;
        rst = 1'b0;
        run_round(0, 0, 8'h00, 1, 0);
        chk("first_spawn_cnt", active_cnt, 1);
        run_round(0, 0, 8'hFF, 1, 0);
        run_round(0, 1, 8'hFF, 1, 0);
        run_round(0, 2, 8'hFF, 1, 0);
        run_round(0, 0, 8'b0000_1010, 0, 0);
        chk("pair_cnt", active_cnt, 2);
        run_round(0, 0, 8'hFF, 0, 0);
        repeat (6) run_round(0, 1, 8'hFF, 1, 0);
        run_round(0, 0, 8'hFF, 1, 0);
        chk("full_cnt", active_cnt, 8);
        run_round(0, 5, 8'hFF, 1, 1);
        force dut.succ_q = 16'hFFFE;
        @(negedge clk);
        release dut.succ_q;
        m_succ = 16'hFFFE;
        run_round(0, 0, 8'h00, 1, 0);
        chk("succ_saturated", succ_cnt, 16'hFFFF);
        repeat (25) run_round(1, 3, 8'h00, 0, 0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        n = 0;
        while (!eval_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_req_seen", eval_req, 1);
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        eval_ack = 1'b1; eval_keep = 1'b1; eval_succ = 1'b1; eval_fail = 1'b1; eval_next_state = 8'hA5;
        repeat (2) @(negedge clk);
        eval_ack = 1'b0; eval_keep = 1'b0; eval_succ = 1'b0; eval_fail = 1'b0;
        @(negedge clk);
        chk_zero("stray_ack");
        chk("rst_overflow_pulses", ov_cnt, exp_ov);
        chk("rst_missed_pulses", mt_cnt, exp_mt);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
